dds_serial_port: RTL and testbench

- Register-write responder behind the controller's wr_start/wr_addr/wr_data/wr_done/wr_out request interface.
- Accepts one register transaction at a time and serialises it onto the DDS chip's 3-wire serial port (CSB, SCLK, bidirectional SDIO). The 8-bit instruction byte is followed by 32 data bits.
- After a write, it pulses IO_UPDATE. After a read, it returns the captured data on wr_out.
- Sits between controller and the DDS pins, alongside the fifo.

---
 rtl/dds_serial_port_pkg.sv | 36 +++
 rtl/dds_serial_port_spi_tick_gen.sv | 49 ++++
 rtl/dds_serial_port.sv | 193 +++++++++++++++++++
 tb/tb_dds_serial_port.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_serial_port_pkg.sv
// Shared definitions for the DDS serial port and its controller.
//   - FSM state encoding (3-bit)
//   - instruction byte layout (READ_BIT, INSTR_BITS)
//   - DDS register addresses used by the controller
//   - helper for sizing the frame bit counter
package dds_serial_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_INSTR  = 3'd2,
        ST_DATA   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_UPDATE = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam int READ_BIT   = 7;
    localparam int INSTR_BITS = 8;

    localparam logic [4:0] REG_CFR1     = 5'h00;
    localparam logic [4:0] REG_CFR2     = 5'h01;
    localparam logic [4:0] REG_CFR3     = 5'h02;
    localparam logic [4:0] REG_FTW      = 5'h07;
    localparam logic [4:0] REG_POW      = 5'h08;
    localparam logic [4:0] REG_ASF      = 5'h09;
    localparam logic [4:0] REG_PROFILE0 = 5'h0E;

    // Bit counter must hold 0..INSTR_BITS+data_bits; never narrower than 6 bits.
    function automatic int bit_cnt_width(input int data_bits);
        int w;
        w = $clog2(INSTR_BITS + data_bits + 1);
        return (w < 6) ? 6 : w;
    endfunction

endpackage

// File: rtl/dds_serial_port_spi_tick_gen.sv
// SCLK half-period timer for the DDS serial port.
//   clk, rst     : system clock, synchronous active-high reset
//   i_en         : count while the frame is active (csb low, SETUP..HOLD)
//   i_run        : high during INSTR/DATA, where sclk actually toggles
//   o_fall_tick  : last cycle of a low-only half (SETUP/HOLD) or of a high
//                  half; the next cycle starts a new bit with sclk low
//   o_rise_tick  : last cycle of a bit's low half; sclk rises on this edge
//   o_phase      : registered sclk level
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_run,
    output logic o_fall_tick,
    output logic o_rise_tick,
    output logic o_phase
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_half_end;

    assign w_half_end  = i_en && (r_cnt == '0);
    assign o_rise_tick = w_half_end && i_run && !r_phase;
    // Outside INSTR/DATA a half period is always a low one, so it ends like a bit.
    assign o_fall_tick = w_half_end && (r_phase || !i_run);
    assign o_phase     = r_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= RELOAD;
            r_phase <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= RELOAD;
            r_phase <= 1'b0;
        end else if (w_half_end) begin
            r_cnt   <= RELOAD;
            r_phase <= i_run ? ~r_phase : 1'b0;
        end else begin
            r_cnt   <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/dds_serial_port.sv
// DDS 3-wire serial port responder.
// Takes one register transaction at a time from the controller and shifts an
// 8-bit instruction plus DATA_BITS data bits MSB first over CSB/SCLK/SDIO.
// Writes finish with an IO_UPDATE pulse; reads return captured data on wr_out.
//   clk, rst          : system clock, synchronous active-high reset
//   wr_start          : request strobe, only looked at in IDLE
//   wr_addr, wr_data  : instruction byte (bit7=read) and write data
//   wr_done           : one-cycle completion pulse
//   wr_out            : last read data, held until the next read completes
//   busy              : accept through wr_done inclusive
//   csb, sclk         : serial chip select (active low) and clock
//   sdio_o, sdio_oe   : serial data out and its enable (tristate built above)
//   sdio_i            : serial data in
//   io_update         : DDS IO_UPDATE strobe
//
// state  | meaning
// IDLE   | waiting for wr_start, csb high
// SETUP  | csb low, first instruction bit on SDIO, sclk low for CLK_DIV
// INSTR  | shifting the 8 instruction bits
// DATA   | shifting (write) or capturing (read) the data bits
// HOLD   | sclk low for CLK_DIV, then csb released
// UPDATE | IO_UPDATE high for UPD_CYCLES (writes only)
// DONE   | wr_done pulse, back to IDLE
module dds_serial_port
    import dds_serial_port_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int DATA_BITS  = 32,
    parameter int UPD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_start,
    input  logic [7:0]           wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 wr_done,
    output logic [DATA_BITS-1:0] wr_out,
    output logic                 busy,
    output logic                 csb,
    output logic                 sclk,
    output logic                 sdio_o,
    output logic                 sdio_oe,
    input  logic                 sdio_i,
    output logic                 io_update
);

    localparam int FRAME_BITS = INSTR_BITS + DATA_BITS;
    localparam int BCW        = bit_cnt_width(DATA_BITS);
    localparam int UCW        = (UPD_CYCLES > 1) ? $clog2(UPD_CYCLES) : 1;

    localparam logic [BCW-1:0] LAST_BIT   = BCW'(FRAME_BITS - 1);
    localparam logic [BCW-1:0] LAST_INSTR = BCW'(INSTR_BITS - 1);

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_tx;
    logic [DATA_BITS-1:0]    r_rx;
    logic                    r_is_read;
    logic [BCW-1:0]          r_bit_cnt;
    logic [UCW-1:0]          r_upd_cnt;
    logic                    r_csb;
    logic                    r_sdio_o;
    logic                    r_sdio_oe;
    logic                    r_busy;
    logic                    r_wr_done;
    logic [DATA_BITS-1:0]    r_wr_out;
    logic                    r_io_update;

    logic w_en;
    logic w_run;
    logic w_fall_tick;
    logic w_rise_tick;
    logic w_phase;

    assign w_en  = !r_csb && (r_state == ST_SETUP || r_state == ST_INSTR ||
                              r_state == ST_DATA  || r_state == ST_HOLD);
    assign w_run = (r_state == ST_INSTR) || (r_state == ST_DATA);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_en),
        .i_run       (w_run),
        .o_fall_tick (w_fall_tick),
        .o_rise_tick (w_rise_tick),
        .o_phase     (w_phase)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_tx        <= '0;
            r_rx        <= '0;
            r_is_read   <= 1'b0;
            r_bit_cnt   <= '0;
            r_upd_cnt   <= '0;
            r_csb       <= 1'b1;
            r_sdio_o    <= 1'b0;
            r_sdio_oe   <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_done   <= 1'b0;
            r_wr_out    <= '0;
            r_io_update <= 1'b0;
        end else begin
            r_wr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wr_start) begin
                        // Bit 7 goes straight to SDIO; r_tx holds the rest, next bit at the MSB.
                        r_tx      <= {wr_addr[6:0], wr_data, 1'b0};
                        r_sdio_o  <= wr_addr[READ_BIT];
                        r_is_read <= wr_addr[READ_BIT];
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_csb     <= 1'b0;
                        r_sdio_oe <= 1'b1;
                        r_state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_fall_tick) begin
                        r_state <= ST_INSTR;
                    end
                end
                ST_INSTR, ST_DATA: begin
                    if (w_rise_tick && r_state == ST_DATA && r_is_read) begin
                        r_rx <= {r_rx[DATA_BITS-2:0], sdio_i};
                    end
                    if (w_fall_tick) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BCW'(1);
                            r_tx      <= {r_tx[FRAME_BITS-2:0], 1'b0};
                            if (r_bit_cnt == LAST_INSTR) begin
                                r_state <= ST_DATA;
                                if (r_is_read) begin
                                    r_sdio_oe <= 1'b0;
                                end
                            end
                            // Bit being started is r_bit_cnt+1; read data bits are not driven.
                            r_sdio_o <= (r_is_read && r_bit_cnt >= LAST_INSTR) ? 1'b0
                                                                                : r_tx[FRAME_BITS-1];
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_fall_tick) begin
                        r_csb     <= 1'b1;
                        r_sdio_oe <= 1'b0;
                        r_sdio_o  <= 1'b0;
                        if (r_is_read) begin
                            r_wr_out  <= r_rx;
                            r_wr_done <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_io_update <= 1'b1;
                            r_upd_cnt   <= UCW'(UPD_CYCLES - 1);
                            r_state     <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (r_upd_cnt == '0) begin
                        r_io_update <= 1'b0;
                        r_wr_done   <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_upd_cnt <= r_upd_cnt - UCW'(1);
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr_done   = r_wr_done;
    assign wr_out    = r_wr_out;
    assign busy      = r_busy;
    assign csb       = r_csb;
    assign sclk      = w_phase;
    assign sdio_o    = r_sdio_o;
    assign sdio_oe   = r_sdio_oe;
    assign io_update = r_io_update;

endmodule

// File: tb/tb_dds_serial_port.sv
// Scoreboard bench for dds_serial_port: the driver pushes an expected frame
// description per accepted request; a monitor rebuilds each SPI frame from the
// pins and compares it against the front of the queue at every wr_done.
module tb_dds_serial_port;

    localparam int CLK_DIV    = 2;
    localparam int UPD_CYCLES = 4;
    localparam int FRAME      = 40;
    localparam int CSB_LOW    = CLK_DIV + FRAME * 2 * CLK_DIV + CLK_DIV;
    localparam int LAT_WR     = 1 + CSB_LOW + UPD_CYCLES;
    localparam int LAT_RD     = 1 + CSB_LOW;
    localparam int OE_RD      = CLK_DIV + 8 * 2 * CLK_DIV;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] out;
        int          gap;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_start = 1'b0;
    logic [7:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        sdio_i = 1'b0;
    logic        wr_done, busy, csb, sclk, sdio_o, sdio_oe, io_update;
    logic [31:0] wr_out;

    logic        d1_start = 1'b0;
    logic [7:0]  d1_addr = '0;
    logic [31:0] d1_data = '0;
    logic        d1_sdio_i = 1'b0;
    logic        d1_done, d1_busy, d1_csb, d1_sclk, d1_sdio_o, d1_sdio_oe, d1_io_update;
    logic [31:0] d1_out;

    always #5 clk = ~clk;

    dds_serial_port dut (
        .clk(clk), .rst(rst), .wr_start(wr_start), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_done(wr_done), .wr_out(wr_out), .busy(busy), .csb(csb), .sclk(sclk),
        .sdio_o(sdio_o), .sdio_oe(sdio_oe), .sdio_i(sdio_i), .io_update(io_update)
    );

    dds_serial_port #(.CLK_DIV(1), .DATA_BITS(32), .UPD_CYCLES(1)) dut_fast (
        .clk(clk), .rst(rst), .wr_start(d1_start), .wr_addr(d1_addr), .wr_data(d1_data),
        .wr_done(d1_done), .wr_out(d1_out), .busy(d1_busy), .csb(d1_csb), .sclk(d1_sclk),
        .sdio_o(d1_sdio_o), .sdio_oe(d1_sdio_oe), .sdio_i(d1_sdio_i), .io_update(d1_io_update)
    );

    int n_tests = 0;
    int n_fail  = 0;
    sb_item_t    exp_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] last_rd = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int          cyc = 0, fcyc = 0, nbits = 0, csb_cnt = 0, oe_cnt = 0;
    int          upd_cnt = 0, upd_first = -1, sclk_hi = 0, nfalls = 0;
    int          last_done = -1, gap = -1, viol = 0;
    bit          in_frame = 0;
    logic        prev_sclk = 1'b0;
    logic [39:0] tx = '0;
    logic [31:0] cur_rd = '0;

    always @(negedge clk) begin
        sb_item_t e;
        bit       rd;
        if (rst) begin
            in_frame  = 0;
            prev_sclk = 1'b0;
        end else begin
            cyc++;
            if (!csb && !in_frame) begin
                in_frame = 1; fcyc = 0; nbits = 0; tx = '0; csb_cnt = 0; oe_cnt = 0;
                upd_cnt = 0; upd_first = -1; sclk_hi = 0; nfalls = 0;
                gap = (last_done >= 0) ? cyc - last_done : -1;
                cur_rd = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
            end
            if (sclk && csb) viol++;
            if (in_frame) begin
                fcyc++;
                if (!csb)    csb_cnt++;
                if (sdio_oe) oe_cnt++;
                if (sclk)    sclk_hi++;
                if (sclk && !prev_sclk) begin
                    tx = {tx[38:0], sdio_o};
                    nbits++;
                end
                if (!sclk && prev_sclk) begin
                    nfalls++;
                    if (nfalls >= 8 && nfalls <= 39) sdio_i = cur_rd[39 - nfalls];
                    else                             sdio_i = 1'($urandom_range(0, 1));
                end
                if (io_update) begin
                    if (upd_first < 0) upd_first = fcyc;
                    upd_cnt++;
                end
                if (wr_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        rd = e.addr[7];
                        chk("frame_bits", nbits, FRAME);
                        chk("instr_byte", tx[39:32], e.addr);
                        if (!rd) chk("write_data", tx[31:0], e.data);
                        chk("done_cycle", fcyc, rd ? LAT_RD : LAT_WR);
                        chk("csb_low_cycles", csb_cnt, CSB_LOW);
                        chk("sdio_oe_cycles", oe_cnt, rd ? OE_RD : CSB_LOW);
                        chk("io_update_cycles", upd_cnt, rd ? 0 : UPD_CYCLES);
                        if (!rd) chk("io_update_start", upd_first, CSB_LOW + 1);
                        chk("sclk_high_cycles", sclk_hi, FRAME * CLK_DIV);
                        chk("wr_out", wr_out, e.out);
                        chk("busy_at_done", busy, 1);
                        chk("invariants", viol, 0);
                        if (e.gap >= 0) chk("b2b_gap", gap, e.gap);
                    end
                    in_frame  = 0;
                    last_done = cyc;
                end
            end else if (wr_done || io_update) begin
                viol++;
            end
            prev_sclk = sclk;
        end
    end

    // ---------------- driver ----------------
    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents a request and returns in the cycle after it was accepted,
    // leaving wr_start high so back-to-back requests can follow.
    task automatic issue(input logic [7:0] a, input logic [31:0] d, input logic [31:0] rv,
                         input bit expect_done, input int gap_exp);
        sb_item_t e;
        bit seen_idle, ok;
        rd_q.push_back(rv);
        if (expect_done) begin
            e.addr = a; e.data = d; e.gap = gap_exp;
            if (a[7]) begin
                e.out   = rv;
                last_rd = rv;
            end else begin
                e.out = last_rd;
            end
            exp_q.push_back(e);
        end
        wr_addr   = a;
        wr_data   = d;
        wr_start  = 1'b1;
        seen_idle = !busy;
        ok        = 0;
        for (int i = 0; i < 600; i++) begin
            wait_cycle();
            if (busy && seen_idle) begin
                ok = 1;
                break;
            end
            if (!busy) seen_idle = 1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        wr_addr = 8'($urandom);
        wr_data = $urandom;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 600; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            wait_cycle();
        end
        if (!ok) chk("idle_timeout", 0, 1);
        wait_cycle();
    endtask

    initial begin
        logic [7:0]  a;
        logic [39:0] ftx;
        int          done_cyc, nrise, last_rise, bad, fupd;
        logic        fprev;

        repeat (3) wait_cycle();
        rst = 1'b0;
        wait_cycle();
        chk("rst_csb", csb, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdio", {sdio_o, sdio_oe}, 0);
        chk("rst_flags", {busy, wr_done, io_update}, 0);
        chk("rst_wr_out", wr_out, 0);

        // directed write and read
        issue(8'h01, 32'h0040_0820, $urandom, 1, -1); wr_start = 1'b0; wait_idle();
        issue(8'h87, 32'h1234_5678, 32'hA5C3_0F12, 1, -1); wr_start = 1'b0; wait_idle();

        // wr_start while busy is dropped
        issue(8'h09, 32'hDEAD_BEEF, $urandom, 1, -1);
        wr_start = 1'b0;
        repeat (49) wait_cycle();
        wr_start = 1'b1; wr_addr = 8'h08; wr_data = 32'h5555_AAAA;
        wait_cycle();
        wr_start = 1'b0;
        wait_idle();

        // back-to-back with wr_start held high
        issue(8'h07, 32'h0123_4567, $urandom, 1, -1);
        issue(8'h88, 32'h0, $urandom, 1, 2);
        issue(8'h0E, 32'h89AB_CDEF, $urandom, 1, 2);
        wr_start = 1'b0;
        wait_idle();

        // reset in the middle of a write
        issue(8'h02, 32'hCAFE_F00D, $urandom, 0, -1);
        wr_start = 1'b0;
        repeat (79) wait_cycle();
        rst = 1'b1;
        wait_cycle();
        rst = 1'b0;
        last_rd = '0;
        chk("abort_csb", csb, 1);
        chk("abort_sclk", sclk, 0);
        chk("abort_sdio_oe", sdio_oe, 0);
        chk("abort_flags", {busy, wr_done, io_update}, 0);
        repeat (5) wait_cycle();
        issue(8'h00, 32'h0000_0001, $urandom, 1, -1); wr_start = 1'b0; wait_idle();

        // randomized traffic
        for (int t = 0; t < 20; t++) begin
            a = {1'($urandom_range(0, 1)), 2'b00, 5'($urandom_range(0, 31))};
            issue(a, $urandom, $urandom, 1, -1);
            wr_start = 1'b0;
            wait_idle();
            repeat ($urandom_range(0, 3)) wait_cycle();
        end
        repeat (10) wait_cycle();
        chk("queue_empty", exp_q.size(), 0);
        chk("invariants_final", viol, 0);

        // CLK_DIV=1, UPD_CYCLES=1 instance
        d1_addr  = 8'h02;
        d1_data  = $urandom;
        d1_start = 1'b1;
        wait_cycle();
        d1_start = 1'b0;
        done_cyc = -1; nrise = 0; last_rise = -1; bad = 0; fupd = 0; ftx = '0; fprev = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (d1_sclk && !fprev) begin
                if (last_rise >= 0 && c - last_rise != 2) bad++;
                last_rise = c;
                ftx = {ftx[38:0], d1_sdio_o};
                nrise++;
            end
            if (d1_sclk && d1_csb) bad++;
            if (d1_io_update) fupd++;
            fprev = d1_sclk;
            if (d1_done) begin
                done_cyc = c;
                break;
            end
            wait_cycle();
        end
        chk("fast_done_cycle", done_cyc, 84);
        chk("fast_rises", nrise, 40);
        chk("fast_sclk_period", bad, 0);
        chk("fast_io_update", fupd, 1);
        chk("fast_frame", ftx, {8'h02, d1_data});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
